// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Holds the scan FSM states, CTRL bit positions and the hex glyph table.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_HEX = 1;

  // Entry n is the a..g pattern for nibble n; bit 7 (dp) is always clear here.
  localparam logic [15:0][7:0] GLYPH = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble-to-glyph decoder: 4-bit value plus decimal point in, 8-bit segment pattern out.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, GLYPH[nib][6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped multiplexed 7-segment scan controller with blank interval between digits.
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter  int DIGITS     = 8,
  parameter  int SCAN_DIV   = 65536,
  parameter  int BLANK_CYC  = 1024,
  parameter  int BLINK_LOG2 = 25,
  localparam int AW         = $clog2(DIGITS / 4 + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [3:0]        be,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] select
);

  localparam int NW   = DIGITS / 4;
  localparam int DW   = $clog2(DIGITS);
  localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);

  logic [DIGITS*8-1:0] data_q;
  logic                en_q;
  logic                hex_q;
  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [DW-1:0]       dig_q;
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;

  logic [DW-1:0]       nxt_dig;
  logic [7:0]          nxt_byte;
  logic [7:0]          hex_seg;
  logic [7:0]          show_seg;
  logic                blink_now;

`ifdef SEG_BLINK_EN
  logic [DIGITS-1:0]   blink_q;
  logic [BLINK_LOG2:0] blink_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) blink_cnt_q <= '0;
    else     blink_cnt_q <= blink_cnt_q + 1'b1;
  end

  // Blink phase is taken at SHOW entry, so a lit digit never flickers mid-slot.
  assign blink_now = blink_cnt_q[BLINK_LOG2] & blink_q[nxt_dig];
`else
  // No blink counter in this build; the parameter only keeps the interface uniform.
  assign blink_now = (BLINK_LOG2 < 0);
`endif

  function automatic logic [DIGITS-1:0] dig_sel(input logic [DW-1:0] d);
    dig_sel = DIGITS'(1) << (DW'(DIGITS - 1) - d);
  endfunction

  // Register file: DATA words, CTRL, and BLINK when blinking is built.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      en_q   <= 1'b0;
      hex_q  <= 1'b0;
`ifdef SEG_BLINK_EN
      blink_q <= '0;
`endif
    end else if (we) begin
      for (int w = 0; w < NW; w++) begin
        if (int'(addr) == w) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) data_q[w*32 + k*8 +: 8] <= din[k*8 +: 8];
          end
        end
      end
      if (int'(addr) == NW && be[0]) begin
        en_q  <= din[CTRL_EN];
        hex_q <= din[CTRL_HEX];
      end
`ifdef SEG_BLINK_EN
      if (int'(addr) == NW + 1) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (be[i/8]) blink_q[i] <= din[i];
        end
      end
`endif
    end
  end

  always_comb begin
    dout = '0;
    if (int'(addr) < NW)       dout = data_q[int'(addr)*32 +: 32];
    else if (int'(addr) == NW) dout = {30'd0, hex_q, en_q};
`ifdef SEG_BLINK_EN
    else if (int'(addr) == NW + 1) dout = 32'(blink_q);
`endif
  end

  always_comb begin
    nxt_dig = '0;
    if (state_q != ST_IDLE && dig_q != DW'(DIGITS - 1)) nxt_dig = dig_q + 1'b1;
  end

  assign nxt_byte = data_q[nxt_dig*8 +: 8];

  seg_hex_decode u_dec (
    .nib (nxt_byte[3:0]),
    .dp  (nxt_byte[7]),
    .seg (hex_seg)
  );

  assign show_seg = blink_now ? 8'h00 : (hex_q ? hex_seg : nxt_byte);

  // Scan FSM: outputs are registered and only load at SHOW entry.
  always_ff @(posedge clk) begin
    if (rst || !en_q) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dig_q   <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_SHOW;
          cnt_q   <= '0;
          dig_q   <= nxt_dig;
          seg_q   <= show_seg;
          sel_q   <= dig_sel(nxt_dig);
        end
        ST_SHOW: begin
          if (cnt_q == CW'(SCAN_DIV - 1)) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            seg_q   <= '0;
            sel_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == CW'(BLANK_CYC - 1)) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            dig_q   <= nxt_dig;
            seg_q   <= show_seg;
            sel_q   <= dig_sel(nxt_dig);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign seg    = seg_q;
  assign select = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=8, SCAN_DIV=4, BLANK_CYC=2, BLINK_LOG2=3).
// Register vectors come from a table; displayed digits are checked against a queue of expected glyphs.
module tb_seg_scan_ctrl;

  localparam int DIGITS     = 8;
  localparam int SCAN_DIV   = 4;
  localparam int BLANK_CYC  = 2;
  localparam int BLINK_LOG2 = 3;
  localparam int AW         = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [AW-1:0]     addr;
  logic [3:0]        be;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic [7:0]        seg;
  logic [DIGITS-1:0] select;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS     (DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .BLINK_LOG2 (BLINK_LOG2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .addr   (addr),
    .be     (be),
    .din    (din),
    .dout   (dout),
    .seg    (seg),
    .select (select)
  );

  typedef struct {
    logic [1:0]  a;
    logic [3:0]  b;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] sel;
  } disp_t;

  int          checks   = 0;
  int          failures = 0;
  disp_t       exp_q[$];
  logic [7:0]  tb_blink = 8'h00;
  logic [3:0]  bc;
  logic [7:0]  prev_sel = 8'h00;
  int          blanked_seen = 0;
  int          lit_seen = 0;
  logic [63:0] raw = 64'h8877665544332211;
  vec_t        tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    addr = a; be = b; din = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] sel);
    disp_t e;
    e.seg = s;
    e.sel = sel;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Reference blink phase: free-running count since reset.
  always @(posedge clk) begin
    if (rst) bc <= 4'd0;
    else     bc <= bc + 4'd1;
  end

  // Scoreboard monitor: every new lit digit must match the head of the queue.
  always @(negedge clk) begin
    disp_t      e;
    logic [7:0] es;
    logic [3:0] bm1;
    if (rst) begin
      prev_sel = 8'h00;
    end else begin
      chk("select_onehot", 32'((select & (select - 8'd1)) == 8'd0), 32'd1);
      if (select != 0 && prev_sel != 0 && select != prev_sel)
        chk("blank_between_digits", {24'd0, select}, 32'd0);
      if (select != 0 && prev_sel == 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_digit", {24'd0, select}, 32'd0);
        end else begin
          e   = exp_q.pop_front();
          es  = e.seg;
          bm1 = bc - 4'd1;
          if ((tb_blink & select) != 0) begin
            if (bm1[3]) begin
              es = 8'h00;
              blanked_seen++;
            end else begin
              lit_seen++;
            end
          end
          chk("scan_sel", {24'd0, select}, {24'd0, e.sel});
          chk("scan_seg", {24'd0, seg}, {24'd0, es});
        end
      end
      prev_sel = select;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos;
    int d;
    rst = 1'b1; we = 1'b0; addr = '0; be = '0; din = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and idle with EN=0
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk("reset_read", dout, 32'd0);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_seg", {24'd0, seg}, 32'd0);
      chk("idle_sel", {24'd0, select}, 32'd0);
    end

    // Register access table
    tbl[0] = '{2'd0, 4'hF, 32'h44332211, 32'h44332211};
    tbl[1] = '{2'd1, 4'hF, 32'h88776655, 32'h88776655};
    tbl[2] = '{2'd0, 4'h5, 32'hAABBCCDD, 32'h44BB22DD};
`ifdef SEG_BLINK_EN
    tbl[3] = '{2'd3, 4'hF, 32'hFFFFFFFF, 32'h000000FF};
`else
    tbl[3] = '{2'd3, 4'hF, 32'hFFFFFFFF, 32'h00000000};
`endif
    tbl[4] = '{2'd3, 4'hF, 32'h00000000, 32'h00000000};
    tbl[5] = '{2'd2, 4'hF, 32'hFFFFFFFC, 32'h00000000};
    tbl[6] = '{2'd2, 4'h1, 32'h00000002, 32'h00000002};
    tbl[7] = '{2'd2, 4'hE, 32'h00000003, 32'h00000002};
    tbl[8] = '{2'd2, 4'h1, 32'h00000000, 32'h00000000};
    tbl[9] = '{2'd0, 4'hF, 32'h44332211, 32'h44332211};
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].a, tbl[i].b, tbl[i].d);
      addr = tbl[i].a;
      #1;
      chk($sformatf("reg_vec%0d", i), dout, tbl[i].exp);
    end

    // Raw scan: one full frame plus digits 0..3 of the next
    for (int k = 0; k < 12; k++) push(raw[(k%8)*8 +: 8], 8'h80 >> (k%8));
    wr(2'd2, 4'h1, 32'd1);
    for (int i = 0; i < 50; i++) begin
      tick();
      pos = i % 6;
      d   = (i / 6) % 8;
      chk("raw_sel", {24'd0, select}, (pos < 4) ? 32'(8'h80 >> d) : 32'd0);
      chk("raw_seg", {24'd0, seg}, (pos < 4) ? {24'd0, raw[d*8 +: 8]} : 32'd0);
    end

    // Disable while digit 3 is lit
    for (int i = 0; i < 60; i++) begin
      if (select == 8'h10) break;
      tick();
    end
    chk("reach_digit3", {24'd0, select}, 32'h10);
    wr(2'd2, 4'h1, 32'd0);
    chk("disable_edge_still_lit", {24'd0, select}, 32'h10);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("disabled_sel", {24'd0, select}, 32'd0);
      chk("disabled_seg", {24'd0, seg}, 32'd0);
    end
    chk("queue_after_disable", 32'(exp_q.size()), 32'd0);

    // Restart from digit 0 and write DATA0 during its SHOW slot
    for (int k = 0; k < 8; k++) push(raw[k*8 +: 8], 8'h80 >> k);
    push(8'hEE, 8'h80);
    wr(2'd2, 4'h1, 32'd1);
    tick();
    chk("restart_sel", {24'd0, select}, 32'h80);
    chk("restart_seg", {24'd0, seg}, 32'h11);
    tick();
    wr(2'd0, 4'h1, 32'h000000EE);
    chk("midshow_seg_kept", {24'd0, seg}, 32'h11);
    tick();
    chk("midshow_seg_last", {24'd0, seg}, 32'h11);
    chk("midshow_sel_last", {24'd0, select}, 32'h80);
    tick();
    chk("after_show_blank", {24'd0, select}, 32'd0);
    wait_empty(80);
    wr(2'd2, 4'h1, 32'd0);
    tick();
    chk("stop_after_new_data", {24'd0, select}, 32'd0);

    // HEX mode with decimal points
    wr(2'd0, 4'hF, 32'h0F8A0000);
    push(8'h3F, 8'h80); push(8'h3F, 8'h40); push(8'hF7, 8'h20); push(8'h71, 8'h10);
    push(8'h6D, 8'h08); push(8'h7D, 8'h04); push(8'h07, 8'h02); push(8'hFF, 8'h01);
    wr(2'd2, 4'h1, 32'd3);
    wait_empty(80);
    wr(2'd2, 4'h1, 32'd0);
    tick();
    chk("hex_stop", {24'd0, select}, 32'd0);

`ifdef SEG_BLINK_EN
    // Blink all digits; entries every 6 cycles cover both 8-cycle phases
    wr(2'd3, 4'hF, 32'h000000FF);
    tb_blink = 8'hFF;
    wr(2'd0, 4'hF, 32'h44332211);
    for (int k = 0; k < 8; k++) push(raw[k*8 +: 8], 8'h80 >> k);
    wr(2'd2, 4'h1, 32'd1);
    wait_empty(80);
    wr(2'd2, 4'h1, 32'd0);
    tick();
    chk("blink_both_phases", 32'(blanked_seen > 0 && lit_seen > 0), 32'd1);
`endif

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised, memory-mapped multiplexed 7-segment display controller on the CPU data bus; the generalised successor to the fixed 8-digit display device.
- Scales to DIGITS digits and adds a control register, optional hex-decode mode, explicit synchronous reset, a programmable scan rate and a deterministic anti-ghosting blank interval.

Parameters:
- DIGITS, 8: digit count; multiple of 4, range 4..32.
- SCAN_DIV, 65536: clk cycles each digit is lit; at least 2.
- BLANK_CYC, 1024: clk cycles all digits are dark between digits; at least 1.
- BLINK_LOG2, 25: blink half-period is 2^BLINK_LOG2 clk cycles. Used only with SEG_BLINK_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write strobe.
- addr  in  AW  word address; AW = $clog2(DIGITS/4+2).
- be  in  4  byte enables; any combination is legal.
- din  in  32  write data.
- dout  out  32  read data; combinational from addr.
- seg  out  8  segment drive, active high (bit0=a .. bit6=g, bit7=dp).
- select  out  DIGITS  digit enable, one-hot or zero, active high.

Behaviour:
- Register map, with NW = DIGITS/4:
  - Words 0..NW-1 are DATA. Digit i is byte i%4 of word i/4.
  - Word NW is CTRL: bit0 EN, bit1 HEX; other bits read 0.
  - Word NW+1 is BLINK: bit i is the blink mask for digit i.
- Writes: on posedge clk with we=1, each byte with be[k]=1 is written. Writes to unmapped addresses are ignored.
- Reads: dout shows the addressed register in the same cycle. Unmapped addresses read 0.
- Reset (rst=1 at posedge): all registers, the prescaler, the digit index and the FSM clear. Outputs seg=0, select=0 from the next edge.
- FSM has three states: IDLE, SHOW, BLANK.
  - IDLE: seg=0, select=0, digit index=0. Moves to SHOW on the cycle after EN is seen as 1.
  - Entering SHOW for digit d: latch seg from the digit's byte. In raw mode that is the byte itself. In HEX mode it is glyph(byte[3:0]) with dp=byte[7]. Set select = 1<<(DIGITS-1-d). Hold for exactly SCAN_DIV cycles, then go to BLANK.
  - BLANK: seg=0, select=0 for exactly BLANK_CYC cycles. Then d = (d==DIGITS-1) ? 0 : d+1, and go to SHOW.
- Digit 0 drives the MSB of select.
- Register writes never alter seg mid-SHOW. New content appears the next time that digit enters SHOW.
- EN cleared in any state: on the next edge go to IDLE, outputs 0, index and prescaler cleared.
- Write coinciding with the SHOW latch edge: the old value is latched.
- At most one select bit is ever high. select never changes directly from one digit to another without at least BLANK_CYC zero cycles in between.
- Each frame lasts DIGITS*(SCAN_DIV+BLANK_CYC) cycles.

Optional Feature:
- Macro SEG_BLINK_EN.
- Defined:
  - A free-running counter of BLINK_LOG2+1 bits runs; it is cleared by rst.
  - When its MSB=1, a digit whose BLINK bit is set shows seg=0 while select still behaves normally.
  - The blink phase is sampled at SHOW entry.
  - BLINK is read/write.
- Not defined: the BLINK word is unmapped (reads 0, writes ignored) and no counter is built.

Decomposition:
- Package seg_pkg holds:
  - the FSM state enum;
  - the CTRL bit indices (CTRL_EN=0, CTRL_HEX=1);
  - the 16-entry glyph constant: 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex).
- One combinational sub-module, seg_hex_decode: 4-bit nibble plus dp bit in, 8-bit seg out.

Test Plan:
All scenarios use DIGITS=8, SCAN_DIV=4, BLANK_CYC=2.
1. Reset and enable
   - Stimulus: rst for 2 cycles, then read every address.
   - Required: all reads 0; seg=0 and select=0 persist for 20 cycles with EN=0.
2. Raw scan
   - Stimulus: write DATA0=0x44332211, DATA1=0x88776655, CTRL=1.
   - Required: select sequence 0x80,0x40,...,0x01, then wraps to 0x80. seg=0x11..0x88 respectively. Each digit is lit 4 cycles with 2 zero cycles between; frame is 48 cycles.
3. Byte enables
   - Stimulus: write DATA0 with din=0xAABBCCDD, be=4'b0101.
   - Required: DATA0 reads 0x44BB22DD.
4. HEX mode
   - Stimulus: DATA0=0x0F8A0000, CTRL=3.
   - Required: seg is 3F, 3F, 77+dp=F7, 71 for digits 0..3; select 0x80..0x10.
5. Disable mid-SHOW and mid-write
   - Stimulus: clear EN during digit 3; separately, write DATA0 during digit 0's SHOW.
   - Required: outputs 0 on the next edge, and restart from select=0x80 after EN is set again. The new DATA0 value appears only on the next frame.
6. Out-of-range address
   - Stimulus: (without SEG_BLINK_EN) write 0xFFFFFFFF to word 3.
   - Required: reads 0. With SEG_BLINK_EN and BLINK_LOG2=3, the masked digit shows seg=0 in alternate 8-cycle phases.
